aib_lane_ctrl: RTL and testbench

// Parametrised, single-clock AIB-style lane controller; successor to the fixed 80-bit AIB wrapper.

---
 rtl/aib_pkg.sv | 26 ++
 rtl/aib_rx_fifo.sv | 61 ++++++
 rtl/aib_lane_ctrl.sv | 143 ++++++++++++++
 tb/tb_aib_lane_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aib_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | aib_pkg : shared state encoding, marker byte and width helper         |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
package aib_pkg;

  localparam logic [2:0] C_ST_IDLE      = 3'd0;
  localparam logic [2:0] C_ST_TX_TRAIN  = 3'd1;
  localparam logic [2:0] C_ST_TX_ACTIVE = 3'd2;
  localparam logic [2:0] C_ST_RX_SEARCH = 3'd3;
  localparam logic [2:0] C_ST_RX_LOCKED = 3'd4;

  localparam logic [7:0] C_MARKER_BYTE = 8'hA5;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aib_rx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | aib_rx_fifo : sync FIFO with flush, full/empty and sticky overflow    |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module aib_rx_fifo
  import aib_pkg::*;
#(
  parameter int DATA_WIDTH = 80,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow
);

  localparam int C_AW = clog2(FIFO_DEPTH);

  logic [C_AW:0]           r_wr_ptr;
  logic [C_AW:0]           r_rd_ptr;
  logic [DATA_WIDTH-1:0]   r_mem [FIFO_DEPTH];
  logic                    r_overflow;
  logic                    w_pop;
  logic                    w_push;

  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[C_AW] != r_rd_ptr[C_AW]) &&
                 (r_wr_ptr[C_AW-1:0] == r_rd_ptr[C_AW-1:0]);

  // A pop frees the slot in the same cycle, so a full FIFO still accepts a write.
  assign w_pop  = rd_en && !empty;
  assign w_push = wr_en && (!full || w_pop);

  assign rd_data  = empty ? '0 : r_mem[r_rd_ptr[C_AW-1:0]];
  assign overflow = r_overflow;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (wr_en && full && !w_pop) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !flush && !rst) r_mem[r_wr_ptr[C_AW-1:0]] <= wr_data;
  end

endmodule
`default_nettype wire

// File: rtl/aib_lane_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | aib_lane_ctrl : AIB-style lane controller, TX train/stream, RX lock   |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module aib_lane_ctrl
  import aib_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 80,
  parameter int                    FIFO_DEPTH   = 8,
  parameter int                    TRAIN_CYCLES = 16,
  parameter int                    LOCK_COUNT   = 4,
  parameter logic [DATA_WIDTH-1:0] MARKER       = {(DATA_WIDTH/8){C_MARKER_BYTE}}
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  mode,
  input  logic [DATA_WIDTH:0]   pad_in,
  output logic [DATA_WIDTH:0]   pad_out,
  output logic [DATA_WIDTH:0]   pad_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  link_up,
  output logic                  overflow
);

  localparam int C_TW = clog2(TRAIN_CYCLES + 1);
  localparam int C_LW = clog2(LOCK_COUNT + 1);
  localparam logic [C_TW-1:0] C_TRAIN_LAST = C_TW'(TRAIN_CYCLES - 1);
  localparam logic [C_LW-1:0] C_LOCK_LAST  = C_LW'(LOCK_COUNT - 1);

  logic [2:0]            r_state;
  logic [2:0]            w_state_nxt;
  logic                  r_mode;
  logic [C_TW-1:0]       r_train_cnt;
  logic [C_LW-1:0]       r_lock_cnt;
  logic [DATA_WIDTH:0]   r_tx_out;
  logic [DATA_WIDTH:0]   r_rx_in;
  logic                  w_abort;
  logic                  w_tx_state;
  logic                  w_rx_state;
  logic                  w_marker_hit;
  logic                  w_flush;
  logic                  w_fifo_wr;
  logic                  w_fifo_empty;
  logic                  w_fifo_full;

  assign w_tx_state   = (r_state == C_ST_TX_TRAIN) || (r_state == C_ST_TX_ACTIVE);
  assign w_rx_state   = (r_state == C_ST_RX_SEARCH) || (r_state == C_ST_RX_LOCKED);
  assign w_abort      = (r_state != C_ST_IDLE) && (!enable || (mode != r_mode));
  assign w_marker_hit = (r_rx_in == {1'b0, MARKER});

  always_comb begin
    w_state_nxt = r_state;
    if (w_abort) begin
      w_state_nxt = C_ST_IDLE;
    end else begin
      case (r_state)
        C_ST_IDLE:      if (enable) w_state_nxt = mode ? C_ST_TX_TRAIN : C_ST_RX_SEARCH;
        C_ST_TX_TRAIN:  if (r_train_cnt == C_TRAIN_LAST) w_state_nxt = C_ST_TX_ACTIVE;
        C_ST_TX_ACTIVE: w_state_nxt = C_ST_TX_ACTIVE;
        C_ST_RX_SEARCH: if (w_marker_hit && (r_lock_cnt == C_LOCK_LAST)) w_state_nxt = C_ST_RX_LOCKED;
        C_ST_RX_LOCKED: w_state_nxt = C_ST_RX_LOCKED;
        default:        w_state_nxt = C_ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= C_ST_IDLE;
      r_mode      <= 1'b0;
      r_train_cnt <= '0;
      r_lock_cnt  <= '0;
      r_tx_out    <= '0;
      r_rx_in     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == C_ST_IDLE && enable) r_mode <= mode;

      if (r_state == C_ST_TX_TRAIN && w_state_nxt == C_ST_TX_TRAIN)
        r_train_cnt <= r_train_cnt + 1'b1;
      else
        r_train_cnt <= '0;

      if (r_state == C_ST_RX_SEARCH && w_state_nxt == C_ST_RX_SEARCH && w_marker_hit)
        r_lock_cnt <= r_lock_cnt + 1'b1;
      else
        r_lock_cnt <= '0;

      // Strobe-low zero word doubles as the idle pattern between transfers.
      if (r_state == C_ST_TX_ACTIVE && !w_abort && tx_valid)
        r_tx_out <= {1'b1, tx_data};
      else
        r_tx_out <= '0;

      r_rx_in <= (w_rx_state && !w_abort) ? pad_in : '0;
    end
  end

  always_comb begin
    pad_out = '0;
    case (r_state)
      C_ST_TX_TRAIN:  pad_out = {1'b0, MARKER};
      C_ST_TX_ACTIVE: pad_out = r_tx_out;
      default:        pad_out = '0;
    endcase
  end

  assign pad_oe   = {(DATA_WIDTH+1){w_tx_state}};
  assign tx_ready = (r_state == C_ST_TX_ACTIVE);
  assign link_up  = (r_state == C_ST_TX_ACTIVE) || (r_state == C_ST_RX_LOCKED);

  assign w_flush   = (r_state == C_ST_IDLE) || w_abort;
  assign w_fifo_wr = (r_state == C_ST_RX_LOCKED) && r_rx_in[DATA_WIDTH];
  assign rx_valid  = !w_fifo_empty;

  aib_rx_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (w_flush),
    .wr_en    (w_fifo_wr),
    .wr_data  (r_rx_in[DATA_WIDTH-1:0]),
    .rd_en    (rx_ready),
    .rd_data  (rx_data),
    .full     (w_fifo_full),
    .empty    (w_fifo_empty),
    .overflow (overflow)
  );

  logic w_unused;
  assign w_unused = w_fifo_full;

endmodule
`default_nettype wire

// File: tb/tb_aib_lane_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_aib_lane_ctrl : directed self-checking bench for aib_lane_ctrl     |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module tb_aib_lane_ctrl;

  localparam int          DW     = 80;
  localparam logic [79:0] MARKER = {10{8'hA5}};

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          mode;
  logic [DW:0]   pad_in;
  logic [DW:0]   pad_out;
  logic [DW:0]   pad_oe;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          link_up;
  logic          overflow;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  aib_lane_ctrl #(
    .DATA_WIDTH   (DW),
    .FIFO_DEPTH   (8),
    .TRAIN_CYCLES (16),
    .LOCK_COUNT   (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .mode     (mode),
    .pad_in   (pad_in),
    .pad_out  (pad_out),
    .pad_oe   (pad_oe),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .link_up  (link_up),
    .overflow (overflow)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Re-enters RX: idle one cycle, then six cycles of markers reach lock.
  task automatic relock();
    enable = 1'b0; mode = 1'b0; pad_in = '0;
    step();
    enable = 1'b1;
    pad_in = {1'b0, MARKER};
    repeat (6) step();
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; mode = 1'b0; pad_in = '0;
    tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b0;
    step(); step();
    n_checks++;
    if ({pad_out, pad_oe} !== '0) begin
      n_fail++; $display("FAIL reset_pads: got out=%h oe=%h, expected 0", pad_out, pad_oe);
    end
    n_checks++;
    if ({tx_ready, rx_valid, link_up, overflow} !== 4'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b, expected 0000", {tx_ready, rx_valid, link_up, overflow});
    end
    n_checks++;
    if (rx_data !== '0) begin
      n_fail++; $display("FAIL reset_rx_data: got %h, expected 0", rx_data);
    end
    rst = 1'b0;
    step();
    n_checks++;
    if (link_up !== 1'b0 || pad_oe !== '0) begin
      n_fail++; $display("FAIL idle_after_reset: got link_up=%b oe=%h, expected 0", link_up, pad_oe);
    end
  endtask

  task automatic test_tx_train();
    mode = 1'b1; enable = 1'b1;
    step();
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (pad_out !== {1'b0, MARKER} || pad_oe !== '1 || link_up !== 1'b0) begin
        n_fail++;
        $display("FAIL tx_train_%0d: got out=%h oe=%h link=%b, expected out=%h oe=all1 link=0",
                 i, pad_out, pad_oe, link_up, {1'b0, MARKER});
      end
      step();
    end
    n_checks++;
    if (link_up !== 1'b1 || tx_ready !== 1'b1 || pad_out !== '0) begin
      n_fail++;
      $display("FAIL tx_active_entry: got link=%b ready=%b out=%h, expected 1 1 0", link_up, tx_ready, pad_out);
    end
  endtask

  task automatic test_tx_active();
    tx_data = 80'h1234; tx_valid = 1'b1;
    step();
    n_checks++;
    if (pad_out !== {1'b1, 80'h1234} || pad_oe !== '1) begin
      n_fail++; $display("FAIL tx_word: got out=%h oe=%h, expected %h", pad_out, pad_oe, {1'b1, 80'h1234});
    end
  endtask

  task automatic test_back_to_back();
    tx_data = 80'hABCD;
    step();
    n_checks++;
    if (pad_out !== {1'b1, 80'hABCD}) begin
      n_fail++; $display("FAIL tx_b2b_1: got %h, expected %h", pad_out, {1'b1, 80'hABCD});
    end
    tx_data = 80'h5;
    step();
    n_checks++;
    if (pad_out !== {1'b1, 80'h5}) begin
      n_fail++; $display("FAIL tx_b2b_2: got %h, expected %h", pad_out, {1'b1, 80'h5});
    end
    tx_valid = 1'b0;
    step();
    n_checks++;
    if (pad_out !== '0 || pad_oe !== '1) begin
      n_fail++; $display("FAIL tx_idle_word: got out=%h oe=%h, expected out=0 oe=all1", pad_out, pad_oe);
    end
  endtask

  task automatic test_mode_change();
    mode = 1'b0;
    step();
    n_checks++;
    if (link_up !== 1'b0 || tx_ready !== 1'b0 || pad_oe !== '0) begin
      n_fail++;
      $display("FAIL mode_change_idle: got link=%b ready=%b oe=%h, expected 0 0 0", link_up, tx_ready, pad_oe);
    end
    enable = 1'b0;
    step();
  endtask

  task automatic test_rx_lock();
    logic [DW:0] seq [8];
    for (int k = 0; k < 8; k++) seq[k] = {1'b0, MARKER};
    seq[3] = {1'b0, 80'hDEAD_BEEF};
    mode = 1'b0; enable = 1'b1; pad_in = '0;
    step();
    for (int k = 0; k < 8; k++) begin
      pad_in = seq[k];
      step();
      n_checks++;
      if (link_up !== 1'b0 || pad_oe !== '0) begin
        n_fail++; $display("FAIL rx_search_%0d: got link=%b oe=%h, expected 0 0", k, link_up, pad_oe);
      end
    end
    pad_in = {1'b0, MARKER};
    step();
    n_checks++;
    if (link_up !== 1'b1) begin
      n_fail++; $display("FAIL rx_lock: got link_up=%b, expected 1", link_up);
    end
    step(); step();
    n_checks++;
    if (rx_valid !== 1'b0) begin
      n_fail++; $display("FAIL rx_marker_ignored: got rx_valid=%b, expected 0", rx_valid);
    end
  endtask

  task automatic test_rx_overflow();
    rx_ready = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      pad_in = {1'b1, 80'(i)};
      step();
      if (i == 1) begin
        n_checks++;
        if (rx_valid !== 1'b0) begin
          n_fail++; $display("FAIL rx_latency_early: got rx_valid=%b, expected 0", rx_valid);
        end
      end
      if (i == 2) begin
        n_checks++;
        if (rx_valid !== 1'b1 || rx_data !== 80'd1) begin
          n_fail++; $display("FAIL rx_latency: got valid=%b data=%h, expected 1 1", rx_valid, rx_data);
        end
      end
      if (i == 9) begin
        n_checks++;
        if (overflow !== 1'b0) begin
          n_fail++; $display("FAIL overflow_early: got %b, expected 0", overflow);
        end
      end
    end
    pad_in = {1'b0, MARKER};
    step(); step();
    n_checks++;
    if (overflow !== 1'b1 || rx_valid !== 1'b1 || rx_data !== 80'd1) begin
      n_fail++;
      $display("FAIL overflow_set: got ovf=%b valid=%b data=%h, expected 1 1 1", overflow, rx_valid, rx_data);
    end
    rx_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      n_checks++;
      if (rx_valid !== 1'b1 || rx_data !== 80'(k)) begin
        n_fail++; $display("FAIL pop_%0d: got valid=%b data=%h, expected 1 %h", k, rx_valid, rx_data, 80'(k));
      end
      step();
    end
    rx_ready = 1'b0;
    n_checks++;
    if (rx_valid !== 1'b0 || rx_data !== '0 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL drained: got valid=%b data=%h ovf=%b, expected 0 0 1", rx_valid, rx_data, overflow);
    end
  endtask

  task automatic test_full_write_pop();
    logic [DW-1:0] exp;
    relock();
    n_checks++;
    if (link_up !== 1'b1 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL relock: got link=%b ovf=%b, expected 1 0", link_up, overflow);
    end
    rx_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      pad_in = {1'b1, 80'(16 + i)};
      step();
    end
    pad_in = {1'b0, MARKER};
    step(); step();
    pad_in = {1'b1, 80'h99};
    step();
    pad_in = {1'b0, MARKER};
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
    n_checks++;
    if (overflow !== 1'b0 || rx_data !== 80'h11) begin
      n_fail++; $display("FAIL full_wr_pop: got ovf=%b head=%h, expected 0 11", overflow, rx_data);
    end
    rx_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      exp = (k < 7) ? 80'(17 + k) : 80'h99;
      n_checks++;
      if (rx_valid !== 1'b1 || rx_data !== exp) begin
        n_fail++; $display("FAIL full_pop_%0d: got valid=%b data=%h, expected 1 %h", k, rx_valid, rx_data, exp);
      end
      step();
    end
    rx_ready = 1'b0;
    n_checks++;
    if (rx_valid !== 1'b0) begin
      n_fail++; $display("FAIL full_count: got rx_valid=%b after 8 pops, expected 0", rx_valid);
    end
  endtask

  task automatic test_flush();
    rx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pad_in = {1'b1, 80'(33 + i)};
      step();
    end
    pad_in = {1'b0, MARKER};
    step(); step();
    n_checks++;
    if (rx_valid !== 1'b1 || rx_data !== 80'h21) begin
      n_fail++; $display("FAIL flush_pre: got valid=%b data=%h, expected 1 21", rx_valid, rx_data);
    end
    enable = 1'b0;
    step();
    n_checks++;
    if (link_up !== 1'b0 || rx_valid !== 1'b0 || overflow !== 1'b0 || rx_data !== '0) begin
      n_fail++;
      $display("FAIL flush: got link=%b valid=%b ovf=%b data=%h, expected 0 0 0 0",
               link_up, rx_valid, overflow, rx_data);
    end
  endtask

  task automatic test_mid_reset();
    relock();
    pad_in = {1'b1, 80'h77};
    step();
    pad_in = {1'b0, MARKER};
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if (link_up !== 1'b0 || rx_valid !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset: got link=%b valid=%b, expected 0 0", link_up, rx_valid);
    end
    step(); step();
    n_checks++;
    if (rx_valid !== 1'b0 || link_up !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_inflight: got valid=%b link=%b, expected 0 0", rx_valid, link_up);
    end
    enable = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_tx_train();
    test_tx_active();
    test_back_to_back();
    test_mode_change();
    test_rx_lock();
    test_rx_overflow();
    test_full_write_pop();
    test_flush();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
